// File: rtl/wb_mon_pkg.sv
// Shared types and constants for the Wishbone transaction monitor.
// Record layout: {ch, kind, we, lat, adr, data}, channel id in the MSBs.
package wb_mon_pkg;

  localparam logic [1:0] KIND_ACK = 2'b00;
  localparam logic [1:0] KIND_ERR = 2'b01;
  localparam logic [1:0] KIND_TMO = 2'b10;
  localparam logic [1:0] KIND_ABT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } ch_state_t;

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int entry_w(
    input int n_ch,
    input int lat_w,
    input int adr_w,
    input int dat_w
  );
    return ch_w(n_ch) + 3 + lat_w + adr_w + dat_w;
  endfunction

  localparam int ENTRY_W = entry_w(2, 8, 32, 32);

endpackage

// File: rtl/wb_mon_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// A pop and a push in the same cycle are both honoured even when full.
module wb_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic                    valid,
  output logic                    full,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = level != '0;
  assign full    = level == (AW+1)'(DEPTH);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_bus_monitor.sv
// Passive Wishbone classic-cycle monitor: per-link transfer FSMs feed
// one-entry holding registers that drain into a shared trace FIFO.
module wb_bus_monitor
  import wb_mon_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAT_W      = 8,
  parameter int TIMEOUT    = 200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [N_CH-1:0]           mon_cyc,
  input  logic [N_CH-1:0]           mon_stb,
  input  logic [N_CH-1:0]           mon_we,
  input  logic [N_CH-1:0]           mon_ack,
  input  logic [N_CH-1:0]           mon_err,
  input  logic [N_CH*ADDR_W-1:0]    mon_adr,
  input  logic [N_CH*DATA_W-1:0]    mon_dat_w,
  input  logic [N_CH*DATA_W-1:0]    mon_dat_r,
  output logic                      trc_valid,
  input  logic                      trc_ready,
  output logic [entry_w(N_CH, LAT_W, ADDR_W, DATA_W)-1:0] trc_data,
  output logic [$clog2(FIFO_DEPTH):0] trc_level,
  output logic                      overflow,
  output logic [15:0]               drop_count
);

  localparam int CH_W = ch_w(N_CH);
  localparam int EW   = entry_w(N_CH, LAT_W, ADDR_W, DATA_W);
  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [LAT_W-1:0] LAT_TMO = LAT_W'(TIMEOUT);

  logic [N_CH-1:0] hold_full;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] drop;
  logic [EW-1:0]   hold_rec [N_CH];
  logic [EW-1:0]   push_data;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic [3:0]      n_drop;
  logic [16:0]     drop_sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t         state;
    ch_state_t         nxt;
    logic [ADDR_W-1:0] adr_in;
    logic [ADDR_W-1:0] adr_q;
    logic [ADDR_W-1:0] adr_d;
    logic              we_q;
    logic              we_d;
    logic [LAT_W-1:0]  lat_q;
    logic [LAT_W-1:0]  lat_d;
    logic [LAT_W-1:0]  lat_inc;
    logic [DATA_W-1:0] dw;
    logic [DATA_W-1:0] dr;
    logic              cyc;
    logic              ack;
    logic              err;
    logic              rec_v;
    logic [1:0]        rec_kind;
    logic              rec_we;
    logic [LAT_W-1:0]  rec_lat;
    logic [ADDR_W-1:0] rec_adr;
    logic [DATA_W-1:0] rec_dat;
    logic              hold_free;
    logic              full_q;
    logic [EW-1:0]     rec_q;

    assign cyc     = mon_cyc[i];
    assign ack     = mon_ack[i];
    assign err     = mon_err[i];
    assign adr_in  = mon_adr[i*ADDR_W +: ADDR_W];
    assign dw      = mon_dat_w[i*DATA_W +: DATA_W];
    assign dr      = mon_dat_r[i*DATA_W +: DATA_W];
    assign lat_inc = (lat_q == LAT_MAX) ? lat_q : lat_q + 1'b1;

    always_comb begin
      nxt      = state;
      adr_d    = adr_q;
      we_d     = we_q;
      lat_d    = lat_q;
      rec_v    = 1'b0;
      rec_kind = KIND_ACK;
      rec_we   = 1'b0;
      rec_lat  = '0;
      rec_adr  = '0;
      rec_dat  = '0;
      if (!enable) begin
        nxt = IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            rec_we  = mon_we[i];
            rec_adr = adr_in;
            rec_dat = mon_we[i] ? dw : dr;
            if (cyc && mon_stb[i]) begin
              if (ack || err) begin
                rec_v    = 1'b1;
                rec_kind = err ? KIND_ERR : KIND_ACK;
              end else begin
                nxt   = ACTIVE;
                adr_d = adr_in;
                we_d  = mon_we[i];
                lat_d = '0;
              end
            end
          end
          ACTIVE: begin
            lat_d   = lat_inc;
            rec_we  = we_q;
            rec_adr = adr_q;
            rec_lat = lat_inc;
            rec_dat = we_q ? dw : dr;
            // cyc loss outranks any stray ack/err seen with it
            if (!cyc) begin
              rec_v    = 1'b1;
              rec_kind = KIND_ABT;
              rec_dat  = '0;
              nxt      = IDLE;
            end else if (err || ack) begin
              rec_v    = 1'b1;
              rec_kind = err ? KIND_ERR : KIND_ACK;
              nxt      = IDLE;
            end else if (lat_inc == LAT_TMO) begin
              rec_v    = 1'b1;
              rec_kind = KIND_TMO;
              rec_dat  = '0;
              nxt      = DRAIN;
            end
          end
          DRAIN: begin
            if (!cyc) nxt = IDLE;
          end
          default: nxt = IDLE;
        endcase
      end
    end

    always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
        state <= IDLE;
        adr_q <= '0;
        we_q  <= 1'b0;
        lat_q <= '0;
      end else begin
        state <= nxt;
        adr_q <= adr_d;
        we_q  <= we_d;
        lat_q <= lat_d;
      end
    end

    // a slot being drained this cycle can take the next record
    assign hold_free = !full_q || grant[i];
    assign drop[i]   = rec_v && !hold_free;

    always_ff @(posedge wb_clk) begin
      if (wb_rst || clear) begin
        full_q <= 1'b0;
        rec_q  <= '0;
      end else if (rec_v && hold_free) begin
        full_q <= 1'b1;
        rec_q  <= {CH_W'(i), rec_kind, rec_we,
                   rec_lat, rec_adr, rec_dat};
      end else if (grant[i]) begin
        full_q <= 1'b0;
      end
    end

    assign hold_full[i] = full_q;
    assign hold_rec[i]  = rec_q;
  end

  assign pop = trc_valid && trc_ready;

  always_comb begin
    grant     = '0;
    push_data = '0;
    if (!clear && (!fifo_full || pop)) begin
      for (int i = 0; i < N_CH; i++) begin
        if (hold_full[i] && grant == '0) begin
          grant[i]  = 1'b1;
          push_data = hold_rec[i];
        end
      end
    end
  end

  assign push = |grant;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_CH; i++) begin
      n_drop = n_drop + 4'(drop[i]);
    end
  end

  assign drop_sum = {1'b0, drop_count} + 17'(n_drop);

  always_ff @(posedge wb_clk) begin
    if (wb_rst || clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (|drop) overflow <= 1'b1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  wb_mon_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .valid     (trc_valid),
    .full      (fifo_full),
    .head      (trc_data),
    .level     (trc_level)
  );

endmodule

// File: tb/tb_wb_bus_monitor.sv
// Bench for wb_bus_monitor: directed scenarios plus randomized
// two-link traffic checked against a transaction-level record model.
module tb_wb_bus_monitor;
  import wb_mon_pkg::*;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int EW = 1 + 2 + 1 + LW + AW + DW;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic clear;
  logic trc_ready;

  logic          c_cyc [NC];
  logic          c_stb [NC];
  logic          c_we  [NC];
  logic          c_ack [NC];
  logic          c_err [NC];
  logic [AW-1:0] c_adr [NC];
  logic [DW-1:0] c_dw  [NC];
  logic [DW-1:0] c_dr  [NC];

  logic [NC-1:0]    mon_cyc;
  logic [NC-1:0]    mon_stb;
  logic [NC-1:0]    mon_we;
  logic [NC-1:0]    mon_ack;
  logic [NC-1:0]    mon_err;
  logic [NC*AW-1:0] mon_adr;
  logic [NC*DW-1:0] mon_dat_w;
  logic [NC*DW-1:0] mon_dat_r;

  logic          trc_valid;
  logic [EW-1:0] trc_data;
  logic [4:0]    trc_level;
  logic          overflow;
  logic [15:0]   drop_count;

  int n_chk = 0;
  int n_fail = 0;
  bit cap = 1'b0;

  logic [EW-1:0] got0 [$];
  logic [EW-1:0] got1 [$];
  logic [EW-1:0] exp0 [$];
  logic [EW-1:0] exp1 [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      mon_cyc[i] = c_cyc[i];
      mon_stb[i] = c_stb[i];
      mon_we[i]  = c_we[i];
      mon_ack[i] = c_ack[i];
      mon_err[i] = c_err[i];
      mon_adr[i*AW +: AW]   = c_adr[i];
      mon_dat_w[i*DW +: DW] = c_dw[i];
      mon_dat_r[i*DW +: DW] = c_dr[i];
    end
  end

  wb_bus_monitor dut (
    .wb_clk     (clk),
    .wb_rst     (rst),
    .enable     (enable),
    .clear      (clear),
    .mon_cyc    (mon_cyc),
    .mon_stb    (mon_stb),
    .mon_we     (mon_we),
    .mon_ack    (mon_ack),
    .mon_err    (mon_err),
    .mon_adr    (mon_adr),
    .mon_dat_w  (mon_dat_w),
    .mon_dat_r  (mon_dat_r),
    .trc_valid  (trc_valid),
    .trc_ready  (trc_ready),
    .trc_data   (trc_data),
    .trc_level  (trc_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always @(negedge clk) begin
    if (cap && trc_valid && trc_ready) begin
      if (trc_data[EW-1]) got1.push_back(trc_data);
      else                got0.push_back(trc_data);
    end
  end

  function automatic logic [EW-1:0] mk(
    input int ch, input logic [1:0] k, input logic we,
    input int lat, input logic [31:0] a, input logic [31:0] d
  );
    return {ch[0], k, we, lat[7:0], a, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ch(input int ch);
    c_cyc[ch] = 0; c_stb[ch] = 0; c_we[ch] = 0;
    c_ack[ch] = 0; c_err[ch] = 0;
  endtask

  task automatic idle_all;
    for (int i = 0; i < NC; i++) idle_ch(i);
  endtask

  task automatic start(input int ch, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    c_cyc[ch] = 1; c_stb[ch] = 1; c_we[ch] = we; c_adr[ch] = a;
    c_dw[ch] = d; c_dr[ch] = d;
  endtask

  task automatic test_reset;
    rst = 1; enable = 1; clear = 0; trc_ready = 0;
    for (int i = 0; i < NC; i++) begin
      idle_ch(i); c_adr[i] = '0; c_dw[i] = '0; c_dr[i] = '0;
    end
    tick; tick;
    rst = 0;
    n_chk += 5;
    if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", trc_valid); end
    if (trc_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", trc_level); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    if (trc_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", trc_data); end
  endtask

  task automatic test_write_ack;
    logic [EW-1:0] e;
    e = mk(0, KIND_ACK, 1, 3, 32'h10, 32'hCAFE);
    start(0, 1, 32'h10, 32'hCAFE);
    c_dr[0] = 32'h5A5A;
    repeat (3) tick;
    c_ack[0] = 1;
    tick;
    idle_all;
    n_chk++;
    if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL wr_hold_stage valid got %0b want 0", trc_valid); end
    tick;
    n_chk += 3;
    if (trc_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid got %0b want 1", trc_valid); end
    if (trc_level !== 5'd1) begin n_fail++; $display("FAIL wr_level got %0d want 1", trc_level); end
    if (trc_data !== e) begin n_fail++; $display("FAIL wr_rec got %h want %h", trc_data, e); end
    trc_ready = 1; tick; trc_ready = 0;
    n_chk++;
    if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL wr_pop valid got %0b want 0", trc_valid); end
  endtask

  task automatic test_read_err;
    logic [EW-1:0] e;
    e = mk(1, KIND_ERR, 0, 1, 32'h2000, 32'h1234);
    start(1, 0, 32'h2000, 32'h1234);
    c_dw[1] = 32'hFFFF_0000;
    tick;
    c_err[1] = 1;
    tick;
    idle_all;
    tick;
    n_chk++;
    if (trc_data !== e) begin n_fail++; $display("FAIL rd_err_rec got %h want %h", trc_data, e); end
    trc_ready = 1; tick; trc_ready = 0;
  endtask

  task automatic test_timeout;
    logic [EW-1:0] e;
    int arrive;
    e = mk(0, KIND_TMO, 0, 200, 32'h300, 32'h0);
    start(0, 0, 32'h300, 32'h77);
    arrive = 0;
    for (int k = 1; k <= 300; k++) begin
      tick;
      if (trc_valid) begin arrive = k; break; end
    end
    n_chk += 2;
    if (arrive != 202) begin n_fail++; $display("FAIL tmo_time got %0d want 202", arrive); end
    if (trc_data !== e) begin n_fail++; $display("FAIL tmo_rec got %h want %h", trc_data, e); end
    trc_ready = 1; tick; trc_ready = 0;
    c_ack[0] = 1;
    tick; tick;
    idle_all;
    repeat (3) tick;
    n_chk++;
    if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_late_ack got valid %0b want 0", trc_valid); end
  endtask

  task automatic test_simul_ack;
    logic [EW-1:0] e0, e1;
    e0 = mk(0, KIND_ACK, 1, 0, 32'hA0, 32'h1111);
    e1 = mk(1, KIND_ACK, 1, 0, 32'hA1, 32'h2222);
    start(0, 1, 32'hA0, 32'h1111);
    start(1, 1, 32'hA1, 32'h2222);
    c_ack[0] = 1; c_ack[1] = 1;
    tick;
    idle_all;
    tick;
    n_chk += 2;
    if (trc_level !== 5'd1) begin n_fail++; $display("FAIL sim_lvl1 got %0d want 1", trc_level); end
    if (trc_data !== e0) begin n_fail++; $display("FAIL sim_first got %h want %h", trc_data, e0); end
    tick;
    n_chk++;
    if (trc_level !== 5'd2) begin n_fail++; $display("FAIL sim_lvl2 got %0d want 2", trc_level); end
    trc_ready = 1; tick; trc_ready = 0;
    n_chk++;
    if (trc_data !== e1) begin n_fail++; $display("FAIL sim_second got %h want %h", trc_data, e1); end
    trc_ready = 1; tick; trc_ready = 0;
  endtask

  task automatic test_back_to_back;
    logic [EW-1:0] e;
    trc_ready = 0;
    for (int k = 0; k < 20; k++) begin
      start(0, 1, 32'(k), 32'hB000 + 32'(k));
      c_ack[0] = 1;
      tick;
    end
    idle_all;
    repeat (3) tick;
    e = mk(0, KIND_ACK, 1, 0, 32'h0, 32'hB000);
    n_chk += 4;
    if (trc_level !== 5'd16) begin n_fail++; $display("FAIL b2b_level got %0d want 16", trc_level); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf got %0b want 1", overflow); end
    if (drop_count !== 16'd3) begin n_fail++; $display("FAIL b2b_drop got %0d want 3", drop_count); end
    if (trc_data !== e) begin n_fail++; $display("FAIL b2b_head got %h want %h", trc_data, e); end
    trc_ready = 1; tick; trc_ready = 0;
    e = mk(0, KIND_ACK, 1, 0, 32'h1, 32'hB001);
    n_chk += 2;
    if (trc_level !== 5'd16) begin n_fail++; $display("FAIL b2b_full_pushpop got %0d want 16", trc_level); end
    if (trc_data !== e) begin n_fail++; $display("FAIL b2b_head2 got %h want %h", trc_data, e); end
    clear = 1; tick; clear = 0;
    n_chk += 3;
    if (trc_level !== 5'd0) begin n_fail++; $display("FAIL clr_level got %0d want 0", trc_level); end
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL clr_drop got %0d want 0", drop_count); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %0b want 0", overflow); end
    repeat (3) tick;
    n_chk++;
    if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL clr_hold got valid %0b want 0", trc_valid); end
  endtask

  task automatic test_enable;
    logic [EW-1:0] e;
    e = mk(0, KIND_ACK, 0, 0, 32'h44, 32'h55);
    start(0, 0, 32'h44, 32'h55);
    c_ack[0] = 1;
    tick;
    idle_all;
    enable = 0;
    tick;
    n_chk += 2;
    if (trc_level !== 5'd1) begin n_fail++; $display("FAIL en_drain_lvl got %0d want 1", trc_level); end
    if (trc_data !== e) begin n_fail++; $display("FAIL en_drain_rec got %h want %h", trc_data, e); end
    start(1, 1, 32'h66, 32'h77);
    tick; tick;
    c_ack[1] = 1;
    tick;
    idle_all;
    tick; tick;
    n_chk++;
    if (trc_level !== 5'd1) begin n_fail++; $display("FAIL en_off_lvl got %0d want 1", trc_level); end
    trc_ready = 1; tick; trc_ready = 0;
    enable = 1;
  endtask

  task automatic test_reset_mid;
    start(0, 1, 32'h8, 32'h9);
    c_ack[0] = 1;
    tick;
    idle_all;
    tick;
    start(1, 0, 32'hC0, 32'hD0);
    repeat (4) tick;
    c_ack[1] = 1;
    rst = 1;
    tick;
    rst = 0;
    idle_all;
    n_chk += 5;
    if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_valid got %0b want 0", trc_valid); end
    if (trc_level !== 5'd0) begin n_fail++; $display("FAIL rstm_level got %0d want 0", trc_level); end
    if (trc_data !== '0) begin n_fail++; $display("FAIL rstm_data got %h want 0", trc_data); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstm_ovf got %0b want 0", overflow); end
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rstm_drop got %0d want 0", drop_count); end
    repeat (4) tick;
    n_chk++;
    if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_partial got valid %0b want 0", trc_valid); end
  endtask

  task automatic drive_ch(input int ch, input int n);
    for (int t = 0; t < n; t++) begin
      int w;
      int r;
      logic we;
      logic [1:0] k;
      logic [31:0] a0, dw, dr, d;
      idle_ch(ch);
      repeat ($urandom_range(1, 3)) tick;
      w = int'($urandom_range(0, 5));
      r = int'($urandom_range(0, 9));
      k = (r < 2) ? KIND_ABT : (r < 5) ? KIND_ERR : KIND_ACK;
      if (k == KIND_ABT && w == 0) w = 1;
      we = 1'($urandom);
      a0 = $urandom;
      dw = '0;
      dr = '0;
      c_we[ch] = we;
      c_adr[ch] = a0;
      for (int c = 0; c <= w; c++) begin
        if (c > 0) c_adr[ch] = $urandom;
        dw = $urandom;
        dr = $urandom;
        c_dw[ch] = dw; c_dr[ch] = dr;
        c_cyc[ch] = 1; c_stb[ch] = 1;
        c_ack[ch] = 0; c_err[ch] = 0;
        if (c == w) begin
          if (k == KIND_ABT) begin
            c_cyc[ch] = 0; c_stb[ch] = 0;
          end else begin
            c_err[ch] = (k == KIND_ERR);
            c_ack[ch] = (k == KIND_ACK) || (r == 4);
          end
        end
        tick;
      end
      d = (k == KIND_ABT) ? 32'h0 : (we ? dw : dr);
      if (ch == 0) exp0.push_back(mk(ch, k, we, w, a0, d));
      else         exp1.push_back(mk(ch, k, we, w, a0, d));
    end
    idle_ch(ch);
  endtask

  task automatic drive_ready(input int n);
    for (int i = 0; i < n; i++) begin
      trc_ready = ($urandom_range(0, 3) != 0);
      tick;
    end
    trc_ready = 1;
  endtask

  task automatic test_random;
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    cap = 1'b1;
    fork
      drive_ch(0, 40);
      drive_ch(1, 40);
      drive_ready(200);
    join
    idle_all;
    trc_ready = 1;
    repeat (30) tick;
    cap = 1'b0;
    trc_ready = 0;
    n_chk += 3;
    if (got0.size() != exp0.size()) begin n_fail++; $display("FAIL rnd_cnt0 got %0d want %0d", got0.size(), exp0.size()); end
    if (got1.size() != exp1.size()) begin n_fail++; $display("FAIL rnd_cnt1 got %0d want %0d", got1.size(), exp1.size()); end
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rnd_drop got %0d want 0", drop_count); end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      n_chk++;
      if (got0[i] !== exp0[i]) begin n_fail++; $display("FAIL rnd_ch0[%0d] got %h want %h", i, got0[i], exp0[i]); end
    end
    for (int i = 0; i < got1.size() && i < exp1.size(); i++) begin
      n_chk++;
      if (got1[i] !== exp1[i]) begin n_fail++; $display("FAIL rnd_ch1[%0d] got %h want %h", i, got1[i], exp1[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_write_ack;
    test_read_err;
    test_timeout;
    test_simul_ack;
    test_back_to_back;
    test_enable;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
